e_mdu: RTL
==========

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits beside the ALU and consumes the same forwarded E-stage operands.
- Runs multi-cycle mult/multu/div/divu into architectural HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Exports Start/Busy so the hazard unit can stall D-stage MDU instructions while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- E_MDU_A  input  32  operand A (forwarded rs value)
- E_MDU_B  input  32  operand B (forwarded rt value)
- E_MDU_op  input  4  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mfhi, 6=mflo, 7=mthi, 8=mtlo; 9-15 treated as none
- Start  output  1  combinational; high when op is 1-4 and Busy=0
- Busy  output  1  registered; high while an operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- E_MDU_out  output  32  combinational; HI for mfhi, LO for mflo, else 0

Behaviour:
- Reset (sync, highest priority): HI=0, LO=0, Busy=0, counter=0, pending results=0. A reset during an operation aborts it: no HI/LO update, Busy=0 the next cycle.
- Start fires at edge N (op 1-4, Busy=0):
  - Full result is captured into pending_hi/pending_lo.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from cycle N+1.
- While Busy:
  - Counter decrements each edge.
  - On the edge where counter==1: HI/LO take the pending values, Busy goes to 0, counter goes to 0.
  - Result: Busy is high for exactly LAT cycles (N+1 .. N+LAT); new HI/LO are visible from cycle N+LAT+1.
- mult: signed 64-bit product of A*B; HI=[63:32], LO=[31:0]. multu: the same, unsigned.
- div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div/divu with B==0): the full Busy sequence still runs; HI/LO keep their pre-op values.
- mthi/mtlo with Busy=0: HI (resp. LO) <= E_MDU_A at the edge.
- mthi/mtlo/mult/div while Busy=1: ignored, no state change. The hazard unit stalls these, so this only arises under stall bugs.
- mfhi/mflo: combinational read of the current HI/LO. No forwarding from pending values; while Busy=1 the hazard unit stalls them.
- Start is purely combinational from E_MDU_op and Busy. The hazard unit treats (Start | Busy) as "MDU occupied".
- Ops none/9-15: no state change.
- Back-to-back: a new Start is accepted in cycle N+LAT+1 (the first cycle with Busy=0).

Test Plan:
- Reset, then op=none -> HI=0, LO=0, Busy=0, E_MDU_out=0.
- mult A=0xFFFFFFFE (-2), B=3 at cycle N -> Start=1 at N; Busy=1 at N+1..N+5 with HI/LO unchanged; at N+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0. Repeat with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- Edge cases:
  - Preload mthi 0x11, mtlo 0x22, then div by B=0 -> Busy 10 cycles, then HI=0x11, LO=0x22.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start a div, assert reset at busy cycle 4 -> next cycle Busy=0, HI=LO=0, no later update. Issuing mult/mthi during Busy -> Start=0, HI/LO unaffected.
- mthi A=0x12345678, next cycle mfhi -> E_MDU_out=0x12345678. mult ends at N+5 and a new mult is issued at N+6 -> accepted (Start=1).

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// The full result is computed combinationally when an operation starts and
// held in pending registers. A down-counter then keeps Busy high for a fixed
// latency, and HI/LO take the pending values on the final busy edge.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   E_MDU_A, E_MDU_B  forwarded rs / rt operands
//   E_MDU_op          0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                     5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
//   Start             combinational: an operation is accepted this cycle
//   Busy              registered: an operation is in flight
//   HI, LO            architectural HI/LO registers
//   E_MDU_out         combinational mfhi/mflo read data, 0 otherwise
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    input  logic [3:0]  E_MDU_op,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDU_out
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;

    logic               w_busy;
    logic               w_is_mdu_op;
    logic               w_start;
    logic               w_last;

    logic signed [63:0] w_sa64;
    logic signed [63:0] w_sb64;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_b_zero;
    logic               w_div_ovf;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic        [31:0] w_b_u;
    logic        [31:0] w_q_u;
    logic        [31:0] w_r_u;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;
    logic               w_res_wr;
    logic [CNT_W-1:0]   w_lat;

    assign w_busy      = (r_state == S_BUSY);
    assign w_is_mdu_op = (E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU) ||
                         (E_MDU_op == OP_DIV)  || (E_MDU_op == OP_DIVU);
    assign w_start     = w_is_mdu_op && !w_busy;
    assign w_last      = w_busy && (r_cnt == CNT_W'(1));

    // Multiply: operands extended to 64 bits so the product is exact.
    assign w_sa64   = {{32{E_MDU_A[31]}}, E_MDU_A};
    assign w_sb64   = {{32{E_MDU_B[31]}}, E_MDU_B};
    assign w_prod_s = w_sa64 * w_sb64;
    assign w_prod_u = {32'd0, E_MDU_A} * {32'd0, E_MDU_B};

    // Divide: a zero divisor or the 0x80000000 / -1 overflow case is replaced
    // by a divisor of 1. For overflow that yields exactly the wrapped result
    // (quotient 0x80000000, remainder 0); for zero the result is discarded.
    assign w_b_zero  = (E_MDU_B == 32'd0);
    assign w_div_ovf = (E_MDU_A == 32'h8000_0000) && (E_MDU_B == 32'hFFFF_FFFF);
    assign w_a_s     = E_MDU_A;
    assign w_b_s     = (w_b_zero || w_div_ovf) ? 32'sd1 : E_MDU_B;
    assign w_q_s     = w_a_s / w_b_s;
    assign w_r_s     = w_a_s % w_b_s;
    assign w_b_u     = w_b_zero ? 32'd1 : E_MDU_B;
    assign w_q_u     = E_MDU_A / w_b_u;
    assign w_r_u     = E_MDU_A % w_b_u;

    // Result selection for the pending registers.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b0;
        w_lat    = CNT_W'(MULT_CYCLES);
        case (E_MDU_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_wr = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_wr = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
                w_res_wr = !w_b_zero;
                w_lat    = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
                w_res_wr = !w_b_zero;
                w_lat    = CNT_W'(DIV_CYCLES);
            end
            default: begin
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter, pending result and HI/LO datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= w_lat;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
        end else if (w_busy) begin
            // Any op arriving while busy is ignored.
            if (w_last) begin
                r_cnt <= '0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else if (E_MDU_op == OP_MTHI) begin
            r_hi <= E_MDU_A;
        end else if (E_MDU_op == OP_MTLO) begin
            r_lo <= E_MDU_A;
        end
    end

    assign Start     = w_start;
    assign Busy      = w_busy;
    assign HI        = r_hi;
    assign LO        = r_lo;
    assign E_MDU_out = (E_MDU_op == OP_MFHI) ? r_hi :
                       (E_MDU_op == OP_MFLO) ? r_lo : 32'd0;

endmodule
